// File: rtl/mem_dcache_access_unit.sv
// MEM-stage DCache access engine: alignment check, strobe/lane build,
// single-outstanding valid/ready request, load extraction and extension.
module mem_dcache_access_unit #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_flush,
  input  logic        mem_advance,
  input  logic        mem_valid,
  input  logic        mem_ld_en,
  input  logic        mem_st_en,
  input  logic [1:0]  mem_size,
  input  logic        mem_ld_sign,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_except_in,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        mem_rdata_valid,
  output logic        mem_adel,
  output logic        mem_ades,
  output logic [31:0] mem_badvaddr,
  output logic        dc_req_valid,
  input  logic        dc_req_ready,
  output logic        dc_req_wr,
  output logic [31:0] dc_req_addr,
  output logic [3:0]  dc_req_wstrb,
  output logic [31:0] dc_req_wdata,
  input  logic        dc_resp_valid,
  input  logic [31:0] dc_resp_rdata
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, DONE, DRAIN
  } state_t;

  state_t      state, state_nx;
  logic        acc, misalign, op;
  logic        is_b, is_h;
  logic [31:0] addr_al;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [31:0] lat_addr, lat_wdata;
  logic [1:0]  lat_size;
  logic        lat_sign, lat_wr;
  logic [3:0]  lat_wstrb;
  logic [31:0] rdata_q, ext;
  logic [7:0]  rb;
  logic [15:0] rh;

  assign acc  = mem_ld_en | mem_st_en;
  assign is_b = (mem_size == 2'd0);
  assign is_h = (mem_size == 2'd1);

  always_comb begin
    misalign = 1'b0;
    addr_al  = mem_addr;
    if (CHECK_ALIGN) begin
      unique case (1'b1)
        is_b:    misalign = 1'b0;
        is_h:    misalign = mem_addr[0];
        default: misalign = |mem_addr[1:0];
      endcase
    end else begin
      // Without checking, low bits are dropped to force alignment.
      unique case (1'b1)
        is_b:    addr_al = mem_addr;
        is_h:    addr_al = {mem_addr[31:1], 1'b0};
        default: addr_al = {mem_addr[31:2], 2'b00};
      endcase
    end
  end

  assign mem_adel     = mem_valid & mem_ld_en & misalign;
  assign mem_ades     = mem_valid & mem_st_en & misalign;
  assign mem_badvaddr = (mem_adel | mem_ades) ? mem_addr : 32'd0;

  assign op = mem_valid & acc & ~misalign & ~mem_except_in & ~mem_flush;

  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = mem_wdata;
    unique case (1'b1)
      is_b: begin
        wstrb_d = 4'b0001 << addr_al[1:0];
        wdata_d = {4{mem_wdata[7:0]}};
      end
      is_h: begin
        wstrb_d = addr_al[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{mem_wdata[15:0]}};
      end
      default: wstrb_d = 4'b1111;
    endcase
    if (!mem_st_en) wstrb_d = 4'b0000;
  end

  assign rb = dc_resp_rdata[{lat_addr[1:0], 3'b000} +: 8];
  assign rh = dc_resp_rdata[{lat_addr[1], 4'b0000} +: 16];

  always_comb begin
    ext = dc_resp_rdata;
    unique case (lat_size)
      2'd0:    ext = {{24{lat_sign & rb[7]}}, rb};
      2'd1:    ext = {{16{lat_sign & rh[15]}}, rh};
      default: ext = dc_resp_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_size  <= 2'd0;
      lat_sign  <= 1'b0;
      lat_wr    <= 1'b0;
      lat_wstrb <= 4'b0000;
      rdata_q   <= 32'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && op) begin
        lat_addr  <= addr_al;
        lat_wdata <= wdata_d;
        lat_size  <= mem_size;
        lat_sign  <= mem_ld_sign;
        lat_wr    <= mem_st_en;
        lat_wstrb <= wstrb_d;
      end
      if (state == WAIT && dc_resp_valid && !mem_flush)
        rdata_q <= ext;
    end
  end

  always_comb begin
    state_nx  = state;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = op;
        if (op) state_nx = REQ;
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dc_req_ready) begin
          // An accepted store is committed even when flushed.
          if (lat_wr) state_nx = mem_flush ? IDLE : DONE;
          else        state_nx = mem_flush ? DRAIN : WAIT;
        end else if (mem_flush) begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (mem_flush) state_nx = dc_resp_valid ? IDLE : DRAIN;
        else if (dc_resp_valid) state_nx = DONE;
      end
      DONE: begin
        if (mem_advance || mem_flush) state_nx = IDLE;
      end
      DRAIN: begin
        // Keep a younger access behind the orphaned response.
        mem_stall = mem_valid & acc;
        if (dc_resp_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dc_req_valid    = (state == REQ);
  assign dc_req_wr       = lat_wr;
  assign dc_req_addr     = lat_addr;
  assign dc_req_wstrb    = lat_wstrb;
  assign dc_req_wdata    = lat_wdata;
  assign mem_rdata       = rdata_q;
  assign mem_rdata_valid = (state == DONE) & ~lat_wr;

endmodule

// File: tb/tb_mem_dcache_access_unit.sv
// Directed vector bench for mem_dcache_access_unit.
module tb_mem_dcache_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_flush, mem_advance, mem_valid;
  logic        mem_ld_en, mem_st_en, mem_ld_sign, mem_except_in;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_stall, mem_rdata_valid, mem_adel, mem_ades;
  logic [31:0] mem_rdata, mem_badvaddr;
  logic        dc_req_valid, dc_req_ready, dc_req_wr;
  logic [31:0] dc_req_addr, dc_req_wdata;
  logic [3:0]  dc_req_wstrb;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = 32'd0;

  always #5 clk = ~clk;

  mem_dcache_access_unit #(.CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .mem_flush(mem_flush), .mem_advance(mem_advance),
    .mem_valid(mem_valid), .mem_ld_en(mem_ld_en),
    .mem_st_en(mem_st_en), .mem_size(mem_size),
    .mem_ld_sign(mem_ld_sign), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_except_in(mem_except_in),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid),
    .mem_adel(mem_adel), .mem_ades(mem_ades),
    .mem_badvaddr(mem_badvaddr),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_wr(dc_req_wr), .dc_req_addr(dc_req_addr),
    .dc_req_wstrb(dc_req_wstrb), .dc_req_wdata(dc_req_wdata),
    .dc_resp_valid(dc_resp_valid), .dc_resp_rdata(dc_resp_rdata)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    int          rdy_dly;
    int          rsp_dly;
    logic        e_exc;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic idle_inputs();
    mem_flush = 1'b0; mem_advance = 1'b0; mem_valid = 1'b0;
    mem_ld_en = 1'b0; mem_st_en = 1'b0; mem_ld_sign = 1'b0;
    mem_except_in = 1'b0; mem_size = 2'd0;
    mem_addr = 32'd0; mem_wdata = 32'd0;
    dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
    dc_resp_rdata = 32'd0;
  endtask

  task automatic drive_op(input logic ld, input logic st,
                          input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d);
    mem_valid = 1'b1; mem_ld_en = ld; mem_st_en = st;
    mem_size = sz; mem_ld_sign = sg; mem_addr = a; mem_wdata = d;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int stalls;
    int want;
    @(negedge clk);
    drive_op(v.ld, v.st, v.size, v.sign, v.addr, v.wdata);
    #1;
    chk($sformatf("v%0d_adel", k), 32'(mem_adel), 32'(v.e_exc & v.ld));
    chk($sformatf("v%0d_ades", k), 32'(mem_ades), 32'(v.e_exc & v.st));
    chk($sformatf("v%0d_badva", k), mem_badvaddr,
        v.e_exc ? v.addr : 32'd0);
    if (v.e_exc) begin
      chk($sformatf("v%0d_exc_stall", k), 32'(mem_stall), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_exc_req", k), 32'(dc_req_valid), 32'd0);
      mem_valid = 1'b0;
      return;
    end
    stalls = mem_stall ? 1 : 0;
    @(negedge clk);
    for (int i = 0; i <= v.rdy_dly; i++) begin
      chk($sformatf("v%0d_rv%0d", k, i), 32'(dc_req_valid), 32'd1);
      chk($sformatf("v%0d_wr%0d", k, i), 32'(dc_req_wr), 32'(v.st));
      chk($sformatf("v%0d_ad%0d", k, i), dc_req_addr, v.addr);
      chk($sformatf("v%0d_ws%0d", k, i), 32'(dc_req_wstrb),
          32'(v.e_wstrb));
      if (v.st)
        chk($sformatf("v%0d_wd%0d", k, i), dc_req_wdata, v.e_wdata);
      if (mem_stall) stalls++;
      dc_req_ready = (i == v.rdy_dly);
      @(negedge clk);
    end
    dc_req_ready = 1'b0;
    if (v.ld) begin
      for (int i = 0; i <= v.rsp_dly; i++) begin
        chk($sformatf("v%0d_wait_rv%0d", k, i), 32'(dc_req_valid), 32'd0);
        if (mem_stall) stalls++;
        dc_resp_valid = (i == v.rsp_dly);
        dc_resp_rdata = (i == v.rsp_dly) ? v.resp : 32'h5A5A_5A5A;
        @(negedge clk);
      end
      dc_resp_valid = 1'b0;
    end
    want = 2 + v.rdy_dly + (v.ld ? v.rsp_dly + 1 : 0);
    chk($sformatf("v%0d_stalls", k), 32'(stalls), 32'(want));
    chk($sformatf("v%0d_done_stall", k), 32'(mem_stall), 32'd0);
    chk($sformatf("v%0d_rvld", k), 32'(mem_rdata_valid), 32'(v.ld));
    if (v.ld) last_rdata = v.e_rdata;
    chk($sformatf("v%0d_rdata", k), mem_rdata, last_rdata);
    mem_advance = 1'b1;
    mem_valid = 1'b0;
    @(negedge clk);
    mem_advance = 1'b0;
    chk($sformatf("v%0d_post_rv", k), 32'(dc_req_valid), 32'd0);
    chk($sformatf("v%0d_post_stall", k), 32'(mem_stall), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,
                 32'hDEAD_BEEF, 0, 1, 1'b0, 4'h0, 32'h0, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h8000_0013, 32'h0,
                 32'h80FF_0000, 0, 0, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h8000_0013, 32'h0,
                 32'h80FF_0000, 1, 2, 1'b0, 4'h0, 32'h0, 32'h0000_0080};
    vecs[3]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h8000_0012, 32'h0,
                 32'h8001_1234, 0, 0, 1'b0, 4'h0, 32'h0, 32'hFFFF_8001};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h8000_0021, 32'h0000_00AB,
                 32'h0, 3, 0, 1'b0, 4'b0010, 32'hABAB_ABAB, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0,
                 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h8000_0001, 32'h1234,
                 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h8000_0044, 32'h1234_5678,
                 32'h0, 0, 0, 1'b0, 4'hF, 32'h1234_5678, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h8000_0046, 32'h0000_BEEF,
                 32'h0, 1, 0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h8000_0010, 32'h0,
                 32'h1234_ABCD, 0, 0, 1'b0, 4'h0, 32'h0, 32'h0000_ABCD};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h8000_0011, 32'h0,
                 32'h0000_7F00, 0, 1, 1'b0, 4'h0, 32'h0, 32'h0000_007F};
    vecs[11] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h8000_0020, 32'h0000_0055,
                 32'h0, 0, 0, 1'b0, 4'b0001, 32'h5555_5555, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h8000_0023, 32'h1234_56C3,
                 32'h0, 0, 0, 1'b0, 4'b1000, 32'hC3C3_C3C3, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 2'd3, 1'b1, 32'h8000_0030, 32'h0,
                 32'h8BAD_F00D, 0, 0, 1'b0, 4'h0, 32'h0, 32'h8BAD_F00D};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(dc_req_valid), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_rvld", 32'(mem_rdata_valid), 32'd0);
    chk("rst_wstrb", 32'(dc_req_wstrb), 32'd0);
    chk("rst_addr", dc_req_addr, 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 14; k++) run_vec(vecs[k], k);

    // Load flushed in WAIT drains; younger SW waits for old response.
    @(negedge clk);
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0100, 32'h0);
    @(negedge clk);
    dc_req_ready = 1'b1;
    @(negedge clk);
    dc_req_ready = 1'b0;
    chk("fl_wait_stall", 32'(mem_stall), 32'd1);
    mem_flush = 1'b1;
    @(negedge clk);
    mem_flush = 1'b0;
    drive_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h8000_0200, 32'hCAFE_F00D);
    #1;
    chk("dr_stall0", 32'(mem_stall), 32'd1);
    chk("dr_rv0", 32'(dc_req_valid), 32'd0);
    @(negedge clk);
    chk("dr_stall1", 32'(mem_stall), 32'd1);
    chk("dr_rv1", 32'(dc_req_valid), 32'd0);
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 32'h1111_1111;
    @(negedge clk);
    dc_resp_valid = 1'b0;
    chk("dr_idle_stall", 32'(mem_stall), 32'd1);
    chk("dr_idle_rv", 32'(dc_req_valid), 32'd0);
    @(negedge clk);
    chk("dr_sw_rv", 32'(dc_req_valid), 32'd1);
    chk("dr_sw_wr", 32'(dc_req_wr), 32'd1);
    chk("dr_sw_addr", dc_req_addr, 32'h8000_0200);
    chk("dr_sw_wdata", dc_req_wdata, 32'hCAFE_F00D);
    chk("dr_sw_wstrb", 32'(dc_req_wstrb), 32'hF);
    dc_req_ready = 1'b1;
    @(negedge clk);
    dc_req_ready = 1'b0;
    chk("dr_done_rvld", 32'(mem_rdata_valid), 32'd0);
    chk("dr_done_rdata", mem_rdata, last_rdata);
    chk("dr_done_stall", 32'(mem_stall), 32'd0);
    mem_advance = 1'b1;
    mem_valid = 1'b0;
    @(negedge clk);
    mem_advance = 1'b0;
    chk("dr_post_rv", 32'(dc_req_valid), 32'd0);

    // Excepted store never reaches the cache.
    drive_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h8000_0300, 32'h1);
    mem_except_in = 1'b1;
    #1;
    chk("exc_stall", 32'(mem_stall), 32'd0);
    chk("exc_ades", 32'(mem_ades), 32'd0);
    @(negedge clk);
    chk("exc_rv", 32'(dc_req_valid), 32'd0);
    mem_except_in = 1'b0;
    mem_valid = 1'b0;

    // Flush in REQ without ready withdraws the request.
    @(negedge clk);
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0340, 32'h0);
    @(negedge clk);
    chk("wd_rv", 32'(dc_req_valid), 32'd1);
    mem_flush = 1'b1;
    @(negedge clk);
    chk("wd_post_rv", 32'(dc_req_valid), 32'd0);
    chk("wd_post_stall", 32'(mem_stall), 32'd0);
    mem_flush = 1'b0;
    mem_valid = 1'b0;

    // Reset while a request is pending.
    @(negedge clk);
    drive_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h8000_0400, 32'h77);
    @(negedge clk);
    chk("rq_rv", 32'(dc_req_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("rq_rst_rv", 32'(dc_req_valid), 32'd0);
    chk("rq_rst_stall", 32'(mem_stall), 32'd0);
    chk("rq_rst_rdata", mem_rdata, 32'd0);
    chk("rq_rst_rvld", 32'(mem_rdata_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
